// File: rtl/mux_arb_2.sv
// mux_arb_2: two-source round-robin burst arbiter driving a shared 2:1 datapath mux
// onto one valid/ready channel, with a per-grant beat cap.
module mux_arb_2 #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    input  logic              last0,
    input  logic              last1,
    output logic              rdy0,
    output logic              rdy1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last,
    input  logic              dout_ready
);
    localparam int CW = $clog2(MAX_BURST);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    state_t        state;
    logic          last_gnt;
    logic [CW-1:0] beat_cnt;
    logic          cap, accept, done, pick0, pick1;
    assign gnt0       = state == GRANT0;
    assign gnt1       = state == GRANT1;
    assign sel        = gnt1;
    assign dout       = sel ? din1 : din0;
    assign cap        = beat_cnt == CW'(MAX_BURST - 1);
    assign dout_valid = (gnt0 & req0) | (gnt1 & req1);
    assign dout_last  = dout_valid & ((sel ? last1 : last0) | cap);
    assign rdy0       = gnt0 & dout_ready;
    assign rdy1       = gnt1 & dout_ready;
    assign accept     = dout_valid & dout_ready;
    assign done       = accept & dout_last;
    // From a grant only the other source may follow; from IDLE ties go away from last_gnt.
    always_comb begin
        pick0 = (state == IDLE) ? req0 & (~req1 | last_gnt) : (state == GRANT1) & req0;
        pick1 = (state == IDLE) ? req1 & ~pick0 : (state == GRANT0) & req1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            beat_cnt <= '0;
        end else if (state == IDLE || done) begin
            beat_cnt <= '0;
            state    <= pick0 ? GRANT0 : pick1 ? GRANT1 : IDLE;
            last_gnt <= pick0 ? 1'b0 : pick1 ? 1'b1 : last_gnt;
        end else if (accept) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_mux_arb_2.sv
// tb_mux_arb_2: scoreboard bench for mux_arb_2; a default instance plus a MAX_BURST=4
// instance share stimulus, and use_cap picks which one the requesters and monitor follow.
module tb_mux_arb_2;
    logic clk = 0, rst = 1;
    logic req0 = 0, req1 = 0, last0 = 0, last1 = 0, dout_ready = 1;
    logic [7:0] din0 = 0, din1 = 0;
    logic a_rdy0, a_rdy1, a_gnt0, a_gnt1, a_sel, a_valid, a_last;
    logic c_rdy0, c_rdy1, c_gnt0, c_gnt1, c_sel, c_valid, c_last;
    logic [7:0] a_dout, c_dout;
    logic m_rdy0, m_rdy1, m_sel, m_valid, m_last;
    logic [7:0] m_dout;
    bit use_cap = 0, hold0 = 0, acc0 = 0, acc1 = 0;
    int tests = 0, fails = 0, cyc = 0;
    int beat_cyc[$];
    typedef struct {logic s; logic [7:0] d; logic l;} exp_t;
    typedef struct {logic [7:0] d; logic l;} src_t;
    exp_t exp_q[$];
    src_t q0[$], q1[$];

    always #5 clk = ~clk;

    mux_arb_2 u_dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .last0(last0), .last1(last1), .rdy0(a_rdy0), .rdy1(a_rdy1), .gnt0(a_gnt0),
        .gnt1(a_gnt1), .sel(a_sel), .dout(a_dout), .dout_valid(a_valid),
        .dout_last(a_last), .dout_ready(dout_ready)
    );
    mux_arb_2 #(.DATA_W(8), .MAX_BURST(4)) u_cap (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .din0(din0), .din1(din1),
        .last0(last0), .last1(last1), .rdy0(c_rdy0), .rdy1(c_rdy1), .gnt0(c_gnt0),
        .gnt1(c_gnt1), .sel(c_sel), .dout(c_dout), .dout_valid(c_valid),
        .dout_last(c_last), .dout_ready(dout_ready)
    );

    assign m_rdy0  = use_cap ? c_rdy0 : a_rdy0;
    assign m_rdy1  = use_cap ? c_rdy1 : a_rdy1;
    assign m_sel   = use_cap ? c_sel : a_sel;
    assign m_dout  = use_cap ? c_dout : a_dout;
    assign m_valid = use_cap ? c_valid : a_valid;
    assign m_last  = use_cap ? c_last : a_last;

    // Requesters: present the queue head, retire it after an edge where it was accepted.
    initial forever begin
        @(posedge clk);
        if (acc0 && q0.size() > 0) q0.delete(0);
        if (acc1 && q1.size() > 0) q1.delete(0);
        #1;
        req0 = q0.size() > 0 && !hold0;
        req1 = q1.size() > 0;
        if (q0.size() > 0) begin din0 = q0[0].d; last0 = q0[0].l; end else last0 = 0;
        if (q1.size() > 0) begin din1 = q1[0].d; last1 = q1[0].l; end else last1 = 0;
    end

    // Monitor: every accepted output beat must match the scoreboard head.
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        acc0 = m_rdy0 & req0;
        acc1 = m_rdy1 & req1;
        if (!rst && m_valid && dout_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_beat: got sel=%0d dout=%h last=%0d, want no beat", m_sel, m_dout, m_last);
            end else begin
                e = exp_q.pop_front();
                beat_cyc.push_back(cyc);
                if ({m_sel, m_dout, m_last} !== {e.s, e.d, e.l}) begin
                    fails++;
                    $display("FAIL beat: got sel=%0d dout=%h last=%0d, want sel=%0d dout=%h last=%0d",
                             m_sel, m_dout, m_last, e.s, e.d, e.l);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #3;
    endtask

    task automatic src_load(input bit s, input int n, input logic [7:0] base, input bit last_end);
        src_t b;
        for (int i = 0; i < n; i++) begin
            b.d = base + 8'(i);
            b.l = last_end && i == n - 1;
            if (s) q1.push_back(b); else q0.push_back(b);
        end
    endtask

    task automatic exp_add(input bit s, input int n, input logic [7:0] base, input int last_at);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.s = s;
            e.d = base + 8'(i);
            e.l = i == last_at;
            exp_q.push_back(e);
        end
    endtask

    function automatic bit probe(input int what);
        return what == 0 ? req0 : what == 1 ? a_gnt0 : what == 2 ? a_gnt1 : c_gnt1;
    endfunction

    task automatic wait_sig(input int what, input string nm);
        int c = 0;
        @(negedge clk);
        while (!probe(what) && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (!probe(what)) begin
            tests++;
            fails++;
            $display("FAIL wait_%s: timed out, got 0 want 1", nm);
        end
    endtask

    task automatic drain(input string nm);
        int c = 0;
        while (exp_q.size() > 0 && c < 100) begin
            @(negedge clk);
            c++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_%s: %0d beats outstanding, want 0", nm, exp_q.size());
        end
    endtask

    task automatic do_reset;
        rst = 1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        hold0 = 0;
        dout_ready = 1;
        repeat (2) @(posedge clk);
        #3 rst = 0;
    endtask

    task automatic test_reset;
        step;
        req0 = 1; req1 = 1; din0 = 8'hA5; din1 = 8'h3C;
        #1;
        tests++;
        if ({a_gnt0, a_gnt1, a_sel, a_valid, a_last, a_rdy0, a_rdy1} !== 7'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {a_gnt0, a_gnt1, a_sel, a_valid, a_last, a_rdy0, a_rdy1});
        end
        tests++;
        if (a_dout !== 8'hA5) begin
            fails++;
            $display("FAIL reset_dout: got %h want a5", a_dout);
        end
        do_reset;
    endtask

    task automatic test_single;
        src_load(0, 1, 8'h11, 1);
        exp_add(0, 1, 8'h11, 0);
        wait_sig(0, "req0");
        tests++;
        if (a_gnt0 !== 1'b0) begin
            fails++;
            $display("FAIL single_latency: gnt0 got %0d want 0", a_gnt0);
        end
        @(negedge clk);
        tests++;
        if ({a_gnt0, a_valid, a_last, a_dout} !== {3'b111, 8'h11}) begin
            fails++;
            $display("FAIL single_beat: got gnt0=%0d valid=%0d last=%0d dout=%h want 1 1 1 11",
                     a_gnt0, a_valid, a_last, a_dout);
        end
        @(negedge clk);
        tests++;
        if ({a_gnt0, a_gnt1} !== 2'b00) begin
            fails++;
            $display("FAIL single_idle: got gnt=%b want 00", {a_gnt1, a_gnt0});
        end
        drain("single");
    endtask

    task automatic test_back_to_back;
        do_reset;
        beat_cyc.delete();
        src_load(0, 3, 8'h20, 1);
        src_load(1, 3, 8'h30, 1);
        exp_add(0, 3, 8'h20, 2);
        exp_add(1, 3, 8'h30, 2);
        drain("b2b");
        tests++;
        if (beat_cyc.size() != 6 || beat_cyc[5] - beat_cyc[0] != 5) begin
            fails++;
            $display("FAIL b2b_bubble: got %0d beats spanning %0d cycles, want 6 spanning 5",
                     beat_cyc.size(), beat_cyc.size() > 0 ? beat_cyc[beat_cyc.size()-1] - beat_cyc[0] : -1);
        end
        step;
        src_load(0, 1, 8'h40, 1);
        src_load(1, 1, 8'h50, 1);
        exp_add(0, 1, 8'h40, 0);
        exp_add(1, 1, 8'h50, 0);
        drain("tie");
    endtask

    task automatic test_ready_stall;
        int n = 0, c = 0;
        step;
        src_load(0, 5, 8'h60, 1);
        exp_add(0, 5, 8'h60, 4);
        while (exp_q.size() > 0 && c < 60) begin
            step;
            dout_ready = ~dout_ready;
            @(negedge clk);
            if (a_rdy0) n++;
            c++;
        end
        dout_ready = 1;
        tests++;
        if (n != 5) begin
            fails++;
            $display("FAIL stall_rdy0: got %0d pulses want 5", n);
        end
        drain("stall");
    endtask

    task automatic test_req_drop;
        step;
        src_load(0, 6, 8'h70, 1);
        exp_add(0, 6, 8'h70, 5);
        exp_add(1, 2, 8'h80, 1);
        wait_sig(1, "gnt0");
        src_load(1, 2, 8'h80, 1);
        @(negedge clk);
        step;
        hold0 = 1;
        wait_sig(3 - 3, "req0_low");
        while (req0) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({a_gnt0, a_gnt1, a_valid} !== 3'b100) begin
                fails++;
                $display("FAIL drop_hold: got gnt0=%0d gnt1=%0d valid=%0d want 1 0 0", a_gnt0, a_gnt1, a_valid);
            end
            @(posedge clk);
            #3;
            if (i == 1) hold0 = 0;
            @(negedge clk);
        end
        drain("drop");
    endtask

    task automatic test_async_reset;
        do_reset;
        src_load(1, 5, 8'h90, 1);
        exp_add(1, 5, 8'h90, 4);
        wait_sig(2, "gnt1");
        @(negedge clk);
        #2 rst = 1;
        #1;
        tests++;
        if ({a_gnt0, a_gnt1, a_sel, a_valid} !== 4'b0) begin
            fails++;
            $display("FAIL async_reset: got gnt0=%0d gnt1=%0d sel=%0d valid=%0d want 0 0 0 0",
                     a_gnt0, a_gnt1, a_sel, a_valid);
        end
        q0.delete();
        q1.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 0;
        step;
        src_load(0, 1, 8'hA0, 1);
        src_load(1, 1, 8'hB0, 1);
        exp_add(0, 1, 8'hA0, 0);
        exp_add(1, 1, 8'hB0, 0);
        drain("post_reset");
    endtask

    task automatic test_cap;
        use_cap = 1;
        do_reset;
        src_load(1, 10, 8'hC0, 0);
        exp_add(1, 4, 8'hC0, 3);
        exp_add(0, 4, 8'hD0, 3);
        exp_add(1, 4, 8'hC4, 3);
        exp_add(1, 2, 8'hC8, -1);
        wait_sig(3, "cap_gnt1");
        src_load(0, 4, 8'hD0, 1);
        drain("cap");
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_ready_stall;
        test_req_drop;
        test_async_reset;
        test_cap;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
